// File: rtl/ahb_sramc_pkg.sv
// Shared encodings and helpers for the AHB-Lite SRAM controller.
package ahb_sramc_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1
    } hresp_e;

    typedef enum logic [1:0] {
        BIST_IDLE  = 2'd0,
        BIST_WRITE = 2'd1,
        BIST_READ  = 2'd2,
        BIST_DONE  = 2'd3
    } bist_state_e;

    localparam logic [31:0] BIST_PATTERN = 32'h5A5A_5A5A;

    function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                             input logic [1:0] addr);
        logic [3:0] m;
        if (size == HSIZE_BYTE)
            m = 4'b0001 << addr;
        else if (size == HSIZE_HALF)
            m = addr[1] ? 4'b1100 : 4'b0011;
        else
            m = 4'b1111;
        return m;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] bist_word(input logic [31:0] idx);
        return idx ^ BIST_PATTERN;
    endfunction

endpackage

// File: rtl/sramc_mem.sv
// Single-clock RAM: one byte-masked write port, one registered read port.
module sramc_mem #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    wmask,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (wmask[b])
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ahb_sramc.sv
// AHB-Lite zero-wait SRAM slave with write-to-read forwarding.
// Optional self-test engine when SRAMC_BIST_EN is defined.
module ahb_sramc
    import ahb_sramc_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hready,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready_resp,
    output logic [1:0]  hresp,
    input  logic        dft_en
`ifdef SRAMC_BIST_EN
   ,input  logic        bist_en,
    output logic        bist_done,
    output logic        bist_fail
`endif
);

    localparam int WW = ADDR_W - 2;

    logic          bist_busy;
    logic          bist_we;
    logic          bist_re;
    logic [WW-1:0] bist_idx;
    logic [31:0]   bist_wdata;

    logic          acc;
    logic [WW-1:0] a_idx;
    logic          wr_pend_d, wr_pend_q;
    logic [WW-1:0] wr_idx_d, wr_idx_q;
    logic [3:0]    wr_mask_d, wr_mask_q;
    logic          rd_d, rd_q;
    logic          fwd_d, fwd_q;
    logic [31:0]   fwd_data_d, fwd_data_q;
    logic [3:0]    fwd_mask_d, fwd_mask_q;

    logic          mem_we;
    logic [3:0]    mem_wmask;
    logic [WW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [WW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;

    logic          unused;
    assign unused = ^{hburst, dft_en, haddr[31:ADDR_W], htrans[0]};

    assign acc   = hsel & hready & htrans[1] & ~bist_busy;
    assign a_idx = haddr[ADDR_W-1:2];

    always_comb begin
        wr_pend_d  = acc & hwrite;
        wr_idx_d   = a_idx;
        wr_mask_d  = lane_mask(hsize, haddr[1:0]);
        rd_d       = acc & ~hwrite;
        // read hits the word whose write data is on the bus right now
        fwd_d      = rd_d & wr_pend_q & (wr_idx_q == a_idx);
        fwd_data_d = hwdata;
        fwd_mask_d = wr_mask_q;
    end

    always_ff @(posedge hclk) begin
        if (hresetn) begin
            wr_pend_q  <= 1'b0;
            wr_idx_q   <= '0;
            wr_mask_q  <= '0;
            rd_q       <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            fwd_mask_q <= '0;
        end else begin
            wr_pend_q  <= wr_pend_d;
            wr_idx_q   <= wr_idx_d;
            wr_mask_q  <= wr_mask_d;
            rd_q       <= rd_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
            fwd_mask_q <= fwd_mask_d;
        end
    end

    always_comb begin
        mem_we    = (wr_pend_q & ~hresetn) | bist_we;
        mem_wmask = bist_we ? 4'hF : wr_mask_q;
        mem_waddr = bist_we ? bist_idx : wr_idx_q;
        mem_wdata = bist_we ? bist_wdata : hwdata;
        mem_raddr = bist_re ? bist_idx : a_idx;
    end

    sramc_mem #(.AW(WW)) u_mem (
        .clk   (hclk),
        .we    (mem_we),
        .wmask (mem_wmask),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_comb begin
        hrdata = '0;
        if (rd_q)
            hrdata = fwd_q ? merge_lanes(mem_rdata, fwd_data_q, fwd_mask_q)
                           : mem_rdata;
    end

    assign hready_resp = 1'b1;
    assign hresp       = HRESP_OKAY;

`ifdef SRAMC_BIST_EN
    bist_state_e   state_d, state_q;
    logic [WW-1:0] idx_d, idx_q;
    logic          chk_d, chk_q;
    logic [WW-1:0] chk_idx_d, chk_idx_q;
    logic          fail_d, fail_q;
    logic          last;

    assign last = (idx_q == {WW{1'b1}});

    always_ff @(posedge hclk) begin
        if (hresetn) begin
            state_q   <= BIST_IDLE;
            idx_q     <= '0;
            chk_q     <= 1'b0;
            chk_idx_q <= '0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            chk_idx_q <= chk_idx_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        chk_d     = 1'b0;
        chk_idx_d = idx_q;
        fail_d    = fail_q;
        if (!bist_en) begin
            state_d = BIST_IDLE;
            idx_d   = '0;
            fail_d  = 1'b0;
        end else begin
            unique case (state_q)
                BIST_IDLE: begin
                    state_d = BIST_WRITE;
                    idx_d   = '0;
                    fail_d  = 1'b0;
                end
                BIST_WRITE: begin
                    idx_d = idx_q + 1'b1;
                    if (last) state_d = BIST_READ;
                end
                BIST_READ: begin
                    chk_d = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (last) state_d = BIST_DONE;
                end
                BIST_DONE: ;
                default: state_d = BIST_IDLE;
            endcase
            if (chk_q && mem_rdata != bist_word(32'(chk_idx_q)))
                fail_d = 1'b1;
        end
    end

    always_comb begin
        bist_busy  = bist_en;
        bist_we    = (state_q == BIST_WRITE);
        bist_re    = (state_q == BIST_READ);
        bist_idx   = idx_q;
        bist_wdata = bist_word(32'(idx_q));
        // last compare lands in the first DONE cycle
        bist_done  = (state_q == BIST_DONE) & ~chk_q;
        bist_fail  = fail_q;
    end
`else
    assign bist_busy  = 1'b0;
    assign bist_we    = 1'b0;
    assign bist_re    = 1'b0;
    assign bist_idx   = '0;
    assign bist_wdata = '0;
`endif

endmodule

// File: tb/tb_ahb_sramc.sv
// Directed bench for ahb_sramc with a word-level reference model.
// Covers the BIST engine when SRAMC_BIST_EN is defined.
module tb_ahb_sramc;

    logic        clk = 1'b0;
    logic        hresetn = 1'b1;
    logic        hsel = 1'b0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = 2'd0;
    logic [2:0]  hsize = 3'd2;
    logic [2:0]  hburst = 3'd0;
    logic        hready = 1'b1;
    logic [31:0] haddr = '0;
    logic [31:0] hwdata = '0;
    logic [31:0] hrdata;
    logic        hready_resp;
    logic [1:0]  hresp;
    logic        dft_en = 1'b0;
`ifdef SRAMC_BIST_EN
    logic        bist_en = 1'b0;
    logic        bist_done;
    logic        bist_fail;
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;
    logic [31:0] model [int];
    logic [31:0] expq [$];
    logic [31:0] wd_next = '0;

    always #5 clk = ~clk;

    ahb_sramc dut (
        .hclk        (clk),
        .hresetn     (hresetn),
        .hsel        (hsel),
        .hwrite      (hwrite),
        .htrans      (htrans),
        .hsize       (hsize),
        .hburst      (hburst),
        .hready      (hready),
        .haddr       (haddr),
        .hwdata      (hwdata),
        .hrdata      (hrdata),
        .hready_resp (hready_resp),
        .hresp       (hresp),
        .dft_en      (dft_en)
`ifdef SRAMC_BIST_EN
       ,.bist_en     (bist_en),
        .bist_done   (bist_done),
        .bist_fail   (bist_fail)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [3:0] lanes(input logic [2:0] sz,
                                         input logic [1:0] a);
        case (sz)
            3'd0:    return 4'b0001 << a;
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        int idx = int'(a[15:2]);
        return model.exists(idx) ? model[idx] : 32'h0;
    endfunction

    task automatic mwrite(input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd);
        int idx = int'(a[15:2]);
        logic [3:0] m = lanes(sz, a[1:0]);
        logic [31:0] w = mread(a);
        for (int b = 0; b < 4; b++)
            if (m[b]) w[8*b +: 8] = wd[8*b +: 8];
        model[idx] = w;
    endtask

    // one address phase; hwdata carries the previous write's data
    task automatic step(input logic sel, input logic [1:0] tr,
                        input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
        logic rd_now;
        @(negedge clk);
        hsel   = sel;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        hwdata = wd_next;
        wd_next = wd;
        rd_now = sel & tr[1] & ~wr;
        if (sel && tr[1] && wr) mwrite(a, sz, wd);
        if (rd_now) expq.push_back(mread(a));
        @(posedge clk);
        #1;
        if (rd_now) chk($sformatf("rd@%h", a), hrdata, expq.pop_front());
        chk("hready_resp", {31'h0, hready_resp}, 32'h1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd);
        step(1'b1, 2'd2, 1'b1, sz, a, wd);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 2'd2, 1'b0, 3'd2, a, 32'h0);
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_hready", {31'h0, hready_resp}, 32'h1);
        chk("rst_hresp", {30'h0, hresp}, 32'h0);
        @(negedge clk);
        hresetn = 1'b0;

        wr(32'h10, 3'd2, 32'h12345678);
        idle();
        rd(32'h10);

        wr(32'h20, 3'd2, 32'h0);
        wr(32'h21, 3'd0, 32'hABABABAB);
        rd(32'h20);
        wr(32'h22, 3'd1, 32'hBEEFBEEF);
        idle();
        rd(32'h20);
        step(1'b1, 2'd2, 1'b0, 3'd1, 32'h22, 32'h0);

        wr(32'h40, 3'd2, 32'hCAFEF00D);
        rd(32'h40);

        wr(32'h80, 3'd2, 32'h55AA55AA);
        step(1'b1, 2'd0, 1'b1, 3'd2, 32'h80, 32'h1);
        step(1'b0, 2'd2, 1'b1, 3'd2, 32'h80, 32'h1);
        step(1'b1, 2'd1, 1'b1, 3'd2, 32'h80, 32'h1);
        idle();
        rd(32'h80);
        wr(32'h83, 3'd0, 32'h77777777);
        rd(32'h80);

        wr(32'h0001_0044, 3'd2, 32'h01020304);
        rd(32'h44);

        wr(32'h54, 3'd2, 32'h99887766);
        wr(32'h50, 3'd2, 32'h11223344);
        rd(32'h54);

        // write whose data phase is cut by reset must be dropped
        wr(32'h100, 3'd2, 32'h11111111);
        wr(32'h100, 3'd2, 32'h22222222);
        @(negedge clk);
        hresetn = 1'b1;
        hsel    = 1'b0;
        htrans  = 2'd0;
        hwdata  = wd_next;
        @(posedge clk);
        #1;
        chk("rst_mid_hrdata", hrdata, 32'h0);
        @(negedge clk);
        hresetn = 1'b0;
        wd_next = '0;
        model[32'h40] = 32'h11111111;
        rd(32'h100);

        for (int i = 0; i < 8; i++)
            wr(32'h200 + 32'(i * 4), 3'd2, $urandom);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = 32'h200 + 32'($urandom_range(0, 7) * 4)
                + 32'($urandom_range(0, 3));
            step(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 2)), a, $urandom);
        end
        idle();

`ifdef SRAMC_BIST_EN
        @(negedge clk);
        hresetn = 1'b1;
        @(negedge clk);
        hresetn = 1'b0;
        bist_en = 1'b1;
        for (int i = 0; i < 2 * (1 << 14) + 20 && !bist_done; i++)
            @(negedge clk);
        chk("bist_done", {31'h0, bist_done}, 32'h1);
        chk("bist_fail", {31'h0, bist_fail}, 32'h0);
        bist_en = 1'b0;
        @(negedge clk);
        chk("bist_done_clr", {31'h0, bist_done}, 32'h0);
        model[3] = 32'h5A5A5A59;
        rd(32'hC);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/ahb_sramc.md
# ahb_sramc

AHB-Lite slave SRAM controller with zero-wait-state single transfers into an on-chip byte-addressable SRAM. It sits on the system AHB bus as a memory slave. The bus master, or the bus wrapper, supplies hsel, hready and the address/control phase signals. Burst type is ignored; every beat is decoded as an independent transfer.

## Interface
- ADDR_W, 16: byte address width; memory is 2^ADDR_W bytes organised as 32-bit words.
- hclk  in  1  single clock for bus and SRAM.
- hresetn  in  1  reset, synchronous and active-high.
- hsel  in  1  slave select.
- hwrite  in  1  1 = write, 0 = read.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hsize  in  3  0 = byte, 1 = halfword, 2 = word.
- hburst  in  3  ignored.
- hready  in  1  bus ready (previous data phase complete).
- haddr  in  32  byte address.
- hwdata  in  32  write data (data phase).
- hrdata  out  32  read data (data phase).
- hready_resp  out  1  slave ready.
- hresp  out  2  always OKAY (00).
- dft_en  in  1  reserved, ignored.

## Operation
- Valid access: `hsel & hready & htrans[1]` in the address phase. IDLE, BUSY and hsel=0 perform no access and leave memory unchanged.
- Word index is haddr[ADDR_W-1:2]; haddr[31:ADDR_W] is ignored, so the memory aliases across the space.
- Byte lanes are little-endian:
  - hsize=0: lane haddr[1:0].
  - hsize=1: lanes {haddr[1],0} and {haddr[1],1}; haddr[0] is ignored.
  - hsize≥2: all four lanes.
- Write:
  - In the address phase, latch the word index, the lane mask and a write flag.
  - In the next cycle (data phase), write the hwdata lanes under the mask.
- Read:
  - Present the word index to the SRAM in the address phase.
  - The full 32-bit word appears on hrdata in the data phase, regardless of hsize.
- Forwarding: if a read address phase coincides with a pending write data phase to the same word, hrdata returns the merged data, i.e. new bytes on the masked lanes and old bytes elsewhere.
- hready_resp is held at 1 and hresp at OKAY for all transfers.
- A reset while a write is pending drops that write. SRAM contents are not cleared by reset.

## Timing
- Reset values: hrdata=0, hready_resp=1, hresp=00; the pending-write flag is cleared.
- Write latency: the SRAM is updated at the clock edge ending the data phase, so a read whose address phase is the next cycle sees the new data.
- Read latency: 1 cycle; hrdata is registered/SRAM output, valid during the data phase.
- Back-to-back transfers of any mix sustain one transfer per cycle.

## Configuration
- SRAMC_BIST_EN defined: adds ports bist_en (in, 1), bist_done (out, 1) and bist_fail (out, 1).
  - States: IDLE, WRITE, READ, DONE.
  - While bist_en=1, AHB accesses are ignored. The engine writes pattern `{index} ^ 32'h5A5A_5A5A` to every word in ascending order, then reads every word and compares it one cycle later.
  - Any mismatch sets bist_fail.
  - In DONE, bist_done=1; bist_done and bist_fail hold until bist_en=0, which returns the engine to IDLE.
  - Reset puts the engine in IDLE with bist_done=0 and bist_fail=0.
  - Memory contents after BIST are the pattern.
- SRAMC_BIST_EN undefined: no BIST ports and no BIST logic.

## Structure
- Package ahb_sramc_pkg holds:
  - htrans, hsize and hresp encodings;
  - the BIST state typedef;
  - the BIST pattern constant.
- Sub-module sramc_mem: synchronous 2^(ADDR_W-2) x 32 RAM with a 4-bit byte-write mask. It has one write port and one read port with registered read data.
- The top level holds the AHB decode, the data-phase registers, the forwarding logic and the optional BIST FSM.

## Test plan
- Reset: assert hresetn for 1 cycle -> hrdata=0, hready_resp=1, hresp=00.
- Word: write 0x12345678 to 0x0010, then read 0x0010 -> 0x12345678; hready_resp stays 1 throughout.
- Byte/halfword:
  - Write word 0 to 0x20.
  - Byte 0xAB to 0x21 -> read 0x0000AB00.
  - Halfword 0xBEEF to 0x22 -> read 0xBEEFAB00.
- Back-to-back: write 0xCAFEF00D to 0x40, then immediately read 0x40 in the next address phase -> 0xCAFEF00D.
- Non-access: write 0x1 to 0x80 with htrans=IDLE, then again with hsel=0 -> a subsequent read of 0x80 returns the prior value unchanged.
- BIST (SRAMC_BIST_EN): pulse reset, hold bist_en=1 -> bist_done=1 and bist_fail=0 after 2·2^(ADDR_W-2)+~3 cycles; a read of word 3 afterwards returns 0x5A5A5A59.
